// File: rtl/memory_access.sv
// MEM stage of the RV32 pipeline. Runs the data-memory req/gnt/rvalid handshake, aligns store lanes,
// extends load data, stalls the front end while an access is open, and owns the MEM/WB register.
package memory_access_pkg;
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_LUI, ALU_AUIPC, ALU_JAL, ALU_JALR, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
        ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW
    } alu_ctrl_e;
endpackage

module memory_access
    import memory_access_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              TIMEOUT_CYCLES = 256,
    parameter logic [XLEN-1:0] RESET_PC       = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            tb_update_i,
    output logic            tb_update_o,
    input  logic [XLEN-1:0] pcM_i,
    input  logic [XLEN-1:0] instrM_i,
    output logic [XLEN-1:0] pcM_o,
    output logic [XLEN-1:0] instrM_o,
    input  alu_ctrl_e       operationM_i,
    input  logic [XLEN-1:0] rdM_data_i,
    input  logic [4:0]      rdM_addr_i,
    input  logic            rdM_wr_ena_i,
    input  logic [XLEN-1:0] memM_addr_i,
    input  logic [XLEN-1:0] memM_wr_data_i,
    input  logic            memM_wr_ena_i,
    output logic [XLEN-1:0] forwM_data_o,
    output logic [4:0]      rdM_addr_fw_o,
    output logic            rdM_wr_ena_fw_o,
    output logic            stall_o,
    output logic            dmem_req_o,
    input  logic            dmem_gnt_i,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] rdW_data_o,
    output logic [4:0]      rdW_addr_o,
    output logic            rdW_wr_ena_o,
    output logic            misaligned_o,
    output logic            bus_err_o
);

    // state  | meaning
    // IDLE   | no access open; an aligned mem op issues its request combinationally
    // REQ    | request presented, waiting for gnt
    // RESP   | request accepted, waiting for rvalid
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_B    = 2'd1;
    localparam logic [1:0] SZ_H    = 2'd2;
    localparam logic [1:0] SZ_W    = 2'd3;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic             w_is_load;
    logic             w_is_store;
    logic [1:0]       w_size;
    logic             w_misaligned;
    logic             w_issue;
    logic             w_cnt_last;
    logic             w_req;
    logic             w_stall;
    logic             w_timeout;
    logic [3:0]       w_be;
    logic [XLEN-1:0]  w_wdata;
    logic [XLEN-1:0]  w_rshift;
    logic [XLEN-1:0]  w_load_data;
    logic [XLEN-1:0]  w_wb_data;
    logic             w_wb_we;

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_instr;
    logic [XLEN-1:0]  r_rd_data;
    logic [4:0]       r_rd_addr;
    logic             r_rd_we;
    logic             r_tb_update;
    logic             r_misaligned;
    logic             r_bus_err;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = SZ_NONE;
        case (operationM_i)
            ALU_LB, ALU_LBU: begin w_is_load  = 1'b1; w_size = SZ_B; end
            ALU_LH, ALU_LHU: begin w_is_load  = 1'b1; w_size = SZ_H; end
            ALU_LW:          begin w_is_load  = 1'b1; w_size = SZ_W; end
            ALU_SB:          begin w_is_store = 1'b1; w_size = SZ_B; end
            ALU_SH:          begin w_is_store = 1'b1; w_size = SZ_H; end
            ALU_SW:          begin w_is_store = 1'b1; w_size = SZ_W; end
            default:         ;
        endcase
    end

    assign w_misaligned = ((w_size == SZ_H) && memM_addr_i[0]) ||
                          ((w_size == SZ_W) && (memM_addr_i[1:0] != 2'b00));

    // Gating with rstn_i keeps the request low while reset is held, even if a mem op sits at the input.
    assign w_issue    = rstn_i && (w_size != SZ_NONE) && !w_misaligned;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_req       = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = dmem_gnt_i ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (w_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                    if (dmem_gnt_i) w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // A response arriving on the last counted cycle still completes normally.
                if (dmem_rvalid_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE || w_state_nxt == S_IDLE) r_cnt <= '0;
            else                                             r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = memM_wr_data_i;
        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << memM_addr_i[1:0];
                w_wdata = {4{memM_wr_data_i[7:0]}};
            end
            SZ_H: begin
                w_be    = memM_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{memM_wr_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_rshift = dmem_rdata_i >> {memM_addr_i[1:0], 3'b000};

    always_comb begin
        w_load_data = w_rshift;
        case (operationM_i)
            ALU_LB:  w_load_data = {{24{w_rshift[7]}}, w_rshift[7:0]};
            ALU_LBU: w_load_data = {24'h0, w_rshift[7:0]};
            ALU_LH:  w_load_data = {{16{w_rshift[15]}}, w_rshift[15:0]};
            ALU_LHU: w_load_data = {16'h0, w_rshift[15:0]};
            default: ;
        endcase
    end

    // The decode store flag also suppresses writeback, so a store never writes rd either way.
    assign w_wb_data = w_is_load ? w_load_data : rdM_data_i;
    assign w_wb_we   = rdM_wr_ena_i && !w_is_store && !memM_wr_ena_i && !w_misaligned && !w_timeout;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pc         <= RESET_PC;
            r_instr      <= XLEN'(32'h13);
            r_rd_data    <= '0;
            r_rd_addr    <= '0;
            r_rd_we      <= 1'b0;
            r_tb_update  <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_pc         <= pcM_i;
            r_instr      <= instrM_i;
            r_rd_data    <= w_wb_data;
            r_rd_addr    <= rdM_addr_i;
            r_rd_we      <= !w_stall && w_wb_we;
            r_tb_update  <= !w_stall && tb_update_i;
            r_misaligned <= !w_stall && w_misaligned;
            r_bus_err    <= w_timeout;
        end
    end

    assign forwM_data_o    = rdM_data_i;
    assign rdM_addr_fw_o   = rdM_addr_i;
    assign rdM_wr_ena_fw_o = rdM_wr_ena_i;

    assign stall_o      = w_stall;
    assign dmem_req_o   = w_req;
    assign dmem_we_o    = w_is_store;
    assign dmem_be_o    = w_be;
    assign dmem_addr_o  = {memM_addr_i[XLEN-1:2], 2'b00};
    assign dmem_wdata_o = w_wdata;

    assign pcM_o        = r_pc;
    assign instrM_o     = r_instr;
    assign rdW_data_o   = r_rd_data;
    assign rdW_addr_o   = r_rd_addr;
    assign rdW_wr_ena_o = r_rd_we;
    assign tb_update_o  = r_tb_update;
    assign misaligned_o = r_misaligned;
    assign bus_err_o    = r_bus_err;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus randomized ops against a
// behavioural model of store lanes, load extension and handshake stall length.
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int          TO  = 16;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        tb_update_i = 1'b0, tb_update_o;
    logic [31:0] pcM_i = '0, instrM_i = '0, pcM_o, instrM_o;
    alu_ctrl_e   operationM_i = ALU_ADD;
    logic [31:0] rdM_data_i = '0;
    logic [4:0]  rdM_addr_i = '0;
    logic        rdM_wr_ena_i = 1'b0;
    logic [31:0] memM_addr_i = '0, memM_wr_data_i = '0;
    logic        memM_wr_ena_i = 1'b0;
    logic [31:0] forwM_data_o;
    logic [4:0]  rdM_addr_fw_o;
    logic        rdM_wr_ena_fw_o, stall_o, dmem_req_o, dmem_we_o;
    logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i = '0;
    logic [31:0] rdW_data_o;
    logic [4:0]  rdW_addr_o;
    logic        rdW_wr_ena_o, misaligned_o, bus_err_o;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int          n_stall;
        int          n_req;
        logic        req_stable;
        logic        bubble_bad;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [31:0] pc_in;
        logic [31:0] wb_pc;
        logic [31:0] wb_data;
        logic [4:0]  wb_addr;
        logic        wb_we;
        logic        wb_mis;
        logic        wb_berr;
        logic        wb_tbu;
    } obs_t;

    memory_access #(.XLEN(32), .TIMEOUT_CYCLES(TO), .RESET_PC(RPC)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .tb_update_i(tb_update_i), .tb_update_o(tb_update_o),
        .pcM_i(pcM_i), .instrM_i(instrM_i), .pcM_o(pcM_o), .instrM_o(instrM_o),
        .operationM_i(operationM_i), .rdM_data_i(rdM_data_i), .rdM_addr_i(rdM_addr_i),
        .rdM_wr_ena_i(rdM_wr_ena_i), .memM_addr_i(memM_addr_i), .memM_wr_data_i(memM_wr_data_i),
        .memM_wr_ena_i(memM_wr_ena_i), .forwM_data_o(forwM_data_o), .rdM_addr_fw_o(rdM_addr_fw_o),
        .rdM_wr_ena_fw_o(rdM_wr_ena_fw_o), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .rdW_data_o(rdW_data_o), .rdW_addr_o(rdW_addr_o),
        .rdW_wr_ena_o(rdW_wr_ena_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Presents one op (entered at posedge+1), plays the memory with gnt at cycle gd and rvalid
    // rvd cycles after that (negative = never), and records what the DUT did.
    task automatic run_op(input alu_ctrl_e op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd_val, input logic [4:0] rd, input int gd,
                          input int rvd, input logic [31:0] rdata, output obs_t o);
        int   cyc;
        logic first;
        o = '{default: 0};
        o.req_stable = 1'b1;
        operationM_i   = op;
        memM_addr_i    = addr;
        memM_wr_data_i = wd;
        rdM_data_i     = rd_val;
        rdM_addr_i     = rd;
        rdM_wr_ena_i   = 1'b1;
        memM_wr_ena_i  = (op inside {ALU_SB, ALU_SH, ALU_SW});
        tb_update_i    = 1'b1;
        pcM_i          = $urandom;
        instrM_i       = $urandom;
        o.pc_in        = pcM_i;
        first = 1'b1;
        cyc   = 0;
        forever begin
            dmem_gnt_i    = (cyc == gd);
            dmem_rvalid_i = (rvd >= 0) && (gd >= 0) && (cyc == gd + rvd);
            dmem_rdata_i  = dmem_rvalid_i ? rdata : ~rdata;
            #4;
            if (stall_o) o.n_stall++;
            if (dmem_req_o) begin
                o.n_req++;
                if (first) begin
                    o.addr = dmem_addr_o; o.be = dmem_be_o; o.wdata = dmem_wdata_o; o.we = dmem_we_o;
                    first = 1'b0;
                end else if (dmem_addr_o !== o.addr || dmem_be_o !== o.be ||
                             dmem_wdata_o !== o.wdata || dmem_we_o !== o.we) begin
                    o.req_stable = 1'b0;
                end
            end
            if (!stall_o) break;
            if (cyc >= 200) begin
                n_cmp++; n_fail++;
                $display("FAIL run_op_bound stall still high after %0d cycles, required release", cyc);
                break;
            end
            @(posedge clk_i); #1;
            if (rdW_wr_ena_o || tb_update_o || misaligned_o || bus_err_o) o.bubble_bad = 1'b1;
            cyc++;
        end
        @(posedge clk_i); #1;
        o.wb_pc   = pcM_o;      o.wb_data = rdW_data_o; o.wb_addr = rdW_addr_o;
        o.wb_we   = rdW_wr_ena_o; o.wb_mis = misaligned_o; o.wb_berr = bus_err_o;
        o.wb_tbu  = tb_update_o;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        operationM_i = ALU_ADD; rdM_wr_ena_i = 1'b0; memM_wr_ena_i = 1'b0; tb_update_i = 1'b0;
    endtask

    // Behavioural expectation for an op that completes (no timeout).
    function automatic obs_t model(input alu_ctrl_e op, input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] rd_val, input int gd, input int rvd,
                                   input logic [31:0] rdata);
        obs_t   e;
        int     size;
        int     off;
        bit     is_st, mis;
        longint v;
        e = '{default: 0};
        off = int'(addr % 4);
        case (op)
            ALU_LB, ALU_LBU, ALU_SB: size = 1;
            ALU_LH, ALU_LHU, ALU_SH: size = 2;
            ALU_LW, ALU_SW:          size = 4;
            default:                 size = 0;
        endcase
        is_st = (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
        mis   = (size == 2 && off % 2 != 0) || (size == 4 && off != 0);
        e.wb_tbu = 1'b1;
        e.wb_mis = mis;
        if (size == 0 || mis) begin
            e.wb_we   = !mis;
            e.wb_data = rd_val;
        end else begin
            e.n_stall = gd + rvd;
            e.n_req   = gd + 1;
            e.addr    = addr - 32'(off);
            e.we      = is_st;
            e.wb_we   = !is_st;
            if (size == 1) begin
                e.be = 4'(1 << off);
                e.wdata = (wd % 256) * 32'h0101_0101;
            end else if (size == 2) begin
                e.be = (off >= 2) ? 4'b1100 : 4'b0011;
                e.wdata = (wd % 65536) * 32'h0001_0001;
            end else begin
                e.be = 4'b1111;
                e.wdata = wd;
            end
            v = longint'(rdata / (32'd1 << (8 * off)));
            case (op)
                ALU_LB:  begin v = v % 256;   if (v >= 128)   v = v - 256;   end
                ALU_LBU: v = v % 256;
                ALU_LH:  begin v = v % 65536; if (v >= 32768) v = v - 65536; end
                ALU_LHU: v = v % 65536;
                default: v = longint'(rdata);
            endcase
            e.wb_data = 32'(v);
        end
        return e;
    endfunction

    task automatic test_reset();
        operationM_i = ALU_LW; memM_addr_i = 32'h8000_0010; rdM_wr_ena_i = 1'b1; tb_update_i = 1'b1;
        dmem_gnt_i = 1'b1;
        #12;
        n_cmp++; if (pcM_o !== RPC) begin n_fail++; $display("FAIL rst_pc got %h want %h", pcM_o, RPC); end
        n_cmp++; if (instrM_o !== 32'h13) begin n_fail++; $display("FAIL rst_instr got %h want 00000013", instrM_o); end
        n_cmp++; if ({rdW_data_o, rdW_addr_o, rdW_wr_ena_o} !== '0) begin n_fail++; $display("FAIL rst_wb got %h/%0d/%b want 0", rdW_data_o, rdW_addr_o, rdW_wr_ena_o); end
        n_cmp++; if ({misaligned_o, bus_err_o, tb_update_o} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b%b%b want 000", misaligned_o, bus_err_o, tb_update_o); end
        n_cmp++; if ({dmem_req_o, stall_o} !== 2'b00) begin n_fail++; $display("FAIL rst_req_stall got %b%b want 00", dmem_req_o, stall_o); end
        dmem_gnt_i = 1'b0; operationM_i = ALU_ADD; rdM_wr_ena_i = 1'b0; tb_update_i = 1'b0;
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_add();
        obs_t o;
        run_op(ALU_ADD, 32'h8000_0001, 32'h0, 32'h1234, 5'd5, 0, 1, 32'h0, o);
        n_cmp++; if (o.n_stall !== 0) begin n_fail++; $display("FAIL add_stall got %0d want 0", o.n_stall); end
        n_cmp++; if (o.n_req !== 0) begin n_fail++; $display("FAIL add_req got %0d want 0", o.n_req); end
        n_cmp++; if (o.wb_data !== 32'h1234) begin n_fail++; $display("FAIL add_data got %h want 00001234", o.wb_data); end
        n_cmp++; if ({o.wb_addr, o.wb_we, o.wb_tbu} !== {5'd5, 1'b1, 1'b1}) begin n_fail++; $display("FAIL add_wb got %0d/%b/%b want 5/1/1", o.wb_addr, o.wb_we, o.wb_tbu); end
        n_cmp++; if (o.wb_pc !== o.pc_in) begin n_fail++; $display("FAIL add_pc got %h want %h", o.wb_pc, o.pc_in); end
        n_cmp++; if ({forwM_data_o, rdM_addr_fw_o, rdM_wr_ena_fw_o} !== {32'h1234, 5'd5, 1'b0}) begin n_fail++; $display("FAIL add_fwd got %h/%0d/%b want 00001234/5/0", forwM_data_o, rdM_addr_fw_o, rdM_wr_ena_fw_o); end
    endtask

    task automatic test_sb();
        obs_t o;
        run_op(ALU_SB, 32'h8000_0103, 32'h0000_00AB, 32'h55, 5'd9, 0, 1, 32'h0, o);
        n_cmp++; if (o.be !== 4'b1000) begin n_fail++; $display("FAIL sb_be got %b want 1000", o.be); end
        n_cmp++; if (o.wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata got %h want abababab", o.wdata); end
        n_cmp++; if (o.addr !== 32'h8000_0100) begin n_fail++; $display("FAIL sb_addr got %h want 80000100", o.addr); end
        n_cmp++; if (o.we !== 1'b1) begin n_fail++; $display("FAIL sb_we got %b want 1", o.we); end
        n_cmp++; if (o.n_stall !== 1) begin n_fail++; $display("FAIL sb_stall got %0d want 1", o.n_stall); end
        n_cmp++; if (o.wb_we !== 1'b0) begin n_fail++; $display("FAIL sb_wb_we got %b want 0", o.wb_we); end
    endtask

    task automatic test_lb_lbu();
        obs_t o;
        run_op(ALU_LB, 32'h8000_0002, 32'h0, 32'h0, 5'd3, 0, 1, 32'h0080_0000, o);
        n_cmp++; if (o.wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data got %h want ffffff80", o.wb_data); end
        n_cmp++; if (o.wb_we !== 1'b1) begin n_fail++; $display("FAIL lb_we got %b want 1", o.wb_we); end
        run_op(ALU_LBU, 32'h8000_0002, 32'h0, 32'h0, 5'd3, 0, 1, 32'h0080_0000, o);
        n_cmp++; if (o.wb_data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_data got %h want 00000080", o.wb_data); end
    endtask

    task automatic test_lh_slow();
        obs_t o;
        run_op(ALU_LH, 32'h8000_0002, 32'h0, 32'h0, 5'd4, 3, 2, 32'h9ABC_1234, o);
        n_cmp++; if (o.n_stall !== 5) begin n_fail++; $display("FAIL lh_stall got %0d want 5", o.n_stall); end
        n_cmp++; if (o.n_req !== 4) begin n_fail++; $display("FAIL lh_req got %0d want 4", o.n_req); end
        n_cmp++; if (o.req_stable !== 1'b1) begin n_fail++; $display("FAIL lh_stable got %b want 1", o.req_stable); end
        n_cmp++; if (o.bubble_bad !== 1'b0) begin n_fail++; $display("FAIL lh_bubble got %b want 0", o.bubble_bad); end
        n_cmp++; if (o.wb_data !== 32'hFFFF_9ABC) begin n_fail++; $display("FAIL lh_data got %h want ffff9abc", o.wb_data); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_op(ALU_LW, 32'h8000_0001, 32'h0, 32'h0, 5'd6, 0, 1, 32'h0, o);
        n_cmp++; if (o.n_req !== 0 || o.n_stall !== 0) begin n_fail++; $display("FAIL mis_lw_req got %0d/%0d want 0/0", o.n_req, o.n_stall); end
        n_cmp++; if ({o.wb_mis, o.wb_we} !== 2'b10) begin n_fail++; $display("FAIL mis_lw_flags got %b%b want 10", o.wb_mis, o.wb_we); end
        run_op(ALU_SH, 32'h8000_0003, 32'h1111, 32'h0, 5'd6, 0, 1, 32'h0, o);
        n_cmp++; if ({o.n_req, o.wb_mis} !== {32'd0, 1'b1}) begin n_fail++; $display("FAIL mis_sh got %0d/%b want 0/1", o.n_req, o.wb_mis); end
        n_cmp++; if (misaligned_o !== 1'b1) begin n_fail++; $display("FAIL mis_hold got %b want 1", misaligned_o); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_op(ALU_LW, 32'h8000_0020, 32'h0, 32'h0, 5'd8, 0, -1, 32'h0, o);
        n_cmp++; if (o.n_stall !== TO) begin n_fail++; $display("FAIL to_stall got %0d want %0d", o.n_stall, TO); end
        n_cmp++; if ({o.wb_berr, o.wb_we} !== 2'b10) begin n_fail++; $display("FAIL to_flags got %b%b want 10", o.wb_berr, o.wb_we); end
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        #4;
        n_cmp++; if ({stall_o, dmem_req_o} !== 2'b00) begin n_fail++; $display("FAIL to_late_rvalid got %b%b want 00", stall_o, dmem_req_o); end
        @(posedge clk_i); #1; dmem_rvalid_i = 1'b0;
        run_op(ALU_LW, 32'h8000_0024, 32'h0, 32'h0, 5'd8, -1, -1, 32'h0, o);
        n_cmp++; if ({o.n_req, o.n_stall} !== {TO, TO}) begin n_fail++; $display("FAIL to_nognt got %0d/%0d want %0d/%0d", o.n_req, o.n_stall, TO, TO); end
        n_cmp++; if (o.wb_berr !== 1'b1) begin n_fail++; $display("FAIL to_nognt_err got %b want 1", o.wb_berr); end
        run_op(ALU_LW, 32'h8000_0028, 32'h0, 32'h0, 5'd8, 0, 1, 32'h2468_ACE0, o);
        n_cmp++; if ({o.n_stall, o.wb_data, o.wb_berr} !== {32'd1, 32'h2468_ACE0, 1'b0}) begin n_fail++; $display("FAIL to_after got %0d/%h/%b want 1/2468ace0/0", o.n_stall, o.wb_data, o.wb_berr); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        operationM_i = ALU_LW; memM_addr_i = 32'h8000_0040; rdM_wr_ena_i = 1'b1; tb_update_i = 1'b1;
        memM_wr_ena_i = 1'b0; dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
        @(posedge clk_i); #1; dmem_gnt_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rm_wait got %b want 1", stall_o); end
        #2; rstn_i = 1'b0; #1;
        n_cmp++; if ({dmem_req_o, stall_o} !== 2'b00) begin n_fail++; $display("FAIL rm_idle got %b%b want 00", dmem_req_o, stall_o); end
        n_cmp++; if ({pcM_o, rdW_wr_ena_o} !== {RPC, 1'b0}) begin n_fail++; $display("FAIL rm_regs got %h/%b want %h/0", pcM_o, rdW_wr_ena_o, RPC); end
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk_i); #1; dmem_rvalid_i = 1'b0; rstn_i = 1'b1;
        run_op(ALU_LW, 32'h8000_0040, 32'h0, 32'h0, 5'd7, 1, 1, 32'h1357_9BDF, o);
        n_cmp++; if ({o.n_stall, o.wb_data, o.wb_we} !== {32'd2, 32'h1357_9BDF, 1'b1}) begin n_fail++; $display("FAIL rm_after got %0d/%h/%b want 2/13579bdf/1", o.n_stall, o.wb_data, o.wb_we); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        run_op(ALU_SW, 32'h8000_0200, 32'hCAFE_F00D, 32'h0, 5'd1, 0, 1, 32'h0, o);
        n_cmp++; if ({o.n_stall, o.be, o.wdata} !== {32'd1, 4'hF, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL b2b_sw got %0d/%b/%h want 1/1111/cafef00d", o.n_stall, o.be, o.wdata); end
        run_op(ALU_LHU, 32'h8000_0202, 32'h0, 32'h0, 5'd2, 0, 1, 32'h8001_7FFF, o);
        n_cmp++; if ({o.n_stall, o.wb_data} !== {32'd1, 32'h0000_8001}) begin n_fail++; $display("FAIL b2b_lhu got %0d/%h want 1/00008001", o.n_stall, o.wb_data); end
        run_op(ALU_XOR, 32'h0, 32'h0, 32'h0F0F_0F0F, 5'd3, 0, 1, 32'h0, o);
        n_cmp++; if ({o.n_stall, o.wb_data, o.wb_we} !== {32'd0, 32'h0F0F_0F0F, 1'b1}) begin n_fail++; $display("FAIL b2b_alu got %0d/%h/%b want 0/0f0f0f0f/1", o.n_stall, o.wb_data, o.wb_we); end
    endtask

    task automatic test_random();
        alu_ctrl_e   ops [10] = '{ALU_ADD, ALU_SUB, ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW};
        obs_t        o, e;
        alu_ctrl_e   op;
        logic [31:0] addr, wd, rv, rdata;
        int          gd, rvd;
        for (int i = 0; i < 60; i++) begin
            op    = ops[$urandom_range(0, 9)];
            addr  = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            wd    = $urandom; rv = $urandom; rdata = $urandom;
            gd    = $urandom_range(0, 3);
            rvd   = $urandom_range(1, 3);
            run_op(op, addr, wd, rv, 5'($urandom), gd, rvd, rdata, o);
            e = model(op, addr, wd, rv, gd, rvd, rdata);
            n_cmp++; if (o.n_stall !== e.n_stall) begin n_fail++; $display("FAIL rnd%0d_stall %s got %0d want %0d", i, op.name(), o.n_stall, e.n_stall); end
            n_cmp++; if (o.n_req !== e.n_req) begin n_fail++; $display("FAIL rnd%0d_req %s got %0d want %0d", i, op.name(), o.n_req, e.n_req); end
            if (e.n_req > 0) begin
                n_cmp++; if ({o.addr, o.be, o.wdata, o.we} !== {e.addr, e.be, e.wdata, e.we}) begin n_fail++; $display("FAIL rnd%0d_bus %s got %h/%b/%h/%b want %h/%b/%h/%b", i, op.name(), o.addr, o.be, o.wdata, o.we, e.addr, e.be, e.wdata, e.we); end
                n_cmp++; if (o.req_stable !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_stable got %b want 1", i, o.req_stable); end
            end
            n_cmp++; if ({o.wb_we, o.wb_mis, o.wb_berr, o.wb_tbu} !== {e.wb_we, e.wb_mis, 1'b0, 1'b1}) begin n_fail++; $display("FAIL rnd%0d_flags %s got %b%b%b%b want %b%b01", i, op.name(), o.wb_we, o.wb_mis, o.wb_berr, o.wb_tbu, e.wb_we, e.wb_mis); end
            if (e.wb_we) begin
                n_cmp++; if (o.wb_data !== e.wb_data) begin n_fail++; $display("FAIL rnd%0d_data %s got %h want %h", i, op.name(), o.wb_data, e.wb_data); end
            end
            n_cmp++; if (o.bubble_bad !== 1'b0 || o.wb_pc !== o.pc_in) begin n_fail++; $display("FAIL rnd%0d_pipe got bubble_bad=%b pc=%h want 0/%h", i, o.bubble_bad, o.wb_pc, o.pc_in); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sb();
        test_lb_lbu();
        test_lh_slow();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
